// File: rtl/blk_ram_arb2.sv
// blk_ram_arb2: two-requester round-robin arbiter/sequencer for one single-port
// block RAM with a registered output (two-stage read: ena latch, then regcea).
// Read data returns to the issuing requester, tagged, two cycles after grant.
//
// Ports
//   clka, rsta                        clock, synchronous active-high reset
//   reqN_valid/we/addr/wdata (in)     requester N command (N = 0, 1)
//   reqN_ready (out)                  requester N command accepted this cycle
//   rsp_valid/rsp_id/rsp_data (out)   read response, originating id, data
//   ram_ena/regcea/wea/addra/dina     RAM drive
//   ram_douta (in)                    RAM registered read data
module blk_ram_arb2 #(
    parameter int unsigned AddrWidth = 12,
    parameter int unsigned DataWidth = 9
) (
    input  logic                 clka,
    input  logic                 rsta,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_we,
    input  logic [AddrWidth-1:0] req0_addr,
    input  logic [DataWidth-1:0] req0_wdata,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_we,
    input  logic [AddrWidth-1:0] req1_addr,
    input  logic [DataWidth-1:0] req1_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [DataWidth-1:0] rsp_data,
    output logic                 ram_ena,
    output logic                 ram_regcea,
    output logic                 ram_wea,
    output logic [AddrWidth-1:0] ram_addra,
    output logic [DataWidth-1:0] ram_dina,
    input  logic [DataWidth-1:0] ram_douta
);

    logic                 r_rr_ptr;
    logic                 r_s1_valid;
    logic                 r_s1_id;
    logic                 r_s2_valid;
    logic                 r_s2_id;

    logic                 w_both;
    logic                 w_gnt_any;
    logic                 w_gnt_id;
    logic                 w_gnt_we;
    logic [AddrWidth-1:0] w_gnt_addr;
    logic [DataWidth-1:0] w_gnt_wdata;

    // Grant selection; nothing is granted while reset is held.
    always_comb begin
        w_both      = req0_valid & req1_valid;
        w_gnt_any   = ~rsta & (req0_valid | req1_valid);
        w_gnt_id    = w_both ? r_rr_ptr : req1_valid;
        w_gnt_we    = w_gnt_id ? req1_we : req0_we;
        w_gnt_addr  = w_gnt_id ? req1_addr : req0_addr;
        w_gnt_wdata = w_gnt_id ? req1_wdata : req0_wdata;
    end

    // Handshake and RAM drive; fields are forced to zero on idle cycles.
    always_comb begin
        req0_ready = w_gnt_any & req0_valid & ~w_gnt_id;
        req1_ready = w_gnt_any & req1_valid & w_gnt_id;
        ram_ena    = w_gnt_any;
        ram_wea    = 1'b0;
        ram_addra  = '0;
        ram_dina   = '0;
        if (w_gnt_any) begin
            ram_wea   = w_gnt_we;
            ram_addra = w_gnt_addr;
            ram_dina  = w_gnt_wdata;
        end
    end

    // Output register loads only for real reads; reset masks stage state
    // that has not yet been cleared by the first reset edge.
    always_comb begin
        ram_regcea = ~rsta & r_s1_valid;
        rsp_valid  = ~rsta & r_s2_valid;
        rsp_id     = ~rsta & r_s2_id;
        rsp_data   = ram_douta;
    end

    // Round-robin pointer and read-tag pipeline.
    always_ff @(posedge clka) begin
        if (rsta) begin
            r_rr_ptr   <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_id    <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_id    <= 1'b0;
        end else begin
            if (w_both) begin
                r_rr_ptr <= ~w_gnt_id;
            end
            r_s1_valid <= w_gnt_any & ~w_gnt_we;
            r_s1_id    <= w_gnt_any & w_gnt_id;
            r_s2_valid <= r_s1_valid;
            r_s2_id    <= r_s1_id;
        end
    end

endmodule
